// File: rtl/sonar_array.sv
// Round-robin HC-SR04 ranging controller: fires one channel at a time and reports echo width or timeout per channel.
// Optional running-average result filter is enabled by defining SONAR_ARRAY_FILTER_EN.
module sonar_array #(
    parameter int N_CH        = 2,
    parameter int TRIG_CYC    = 500,
    parameter int TIMEOUT_CYC = 1500000,
    parameter int GAP_CYC     = 50000,
    parameter int RES_W       = 32
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic                   enable,
    input  logic [N_CH-1:0]        echo,
    output logic [N_CH-1:0]        trig,
    output logic [N_CH*RES_W-1:0]  result,
    output logic [N_CH-1:0]        valid,
    output logic [N_CH-1:0]        timeout,
    output logic                   busy,
    output logic [2:0]             dbg_state_o,
    output logic [3:0]             dbg_ch_o
);

    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TCNT_W = $clog2(TIMEOUT_CYC) + 1;

    localparam logic [31:0]       TRIG_LAST = 32'(TRIG_CYC - 1);
    localparam logic [31:0]       GAP_LAST  = 32'(GAP_CYC - 1);
    localparam logic [TCNT_W-1:0] TO_LAST   = TCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [N_CH-1:0]   CH_ONE    = N_CH'(1);

    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
        $error("sonar_array: N_CH must be in 1..16");
    end
    if (TRIG_CYC < 1 || GAP_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cyc
        $error("sonar_array: cycle parameters must be at least 1");
    end
    if ((RES_W < 63) && (longint'(TIMEOUT_CYC) >= (longint'(1) << RES_W))) begin : g_bad_resw
        $error("sonar_array: TIMEOUT_CYC must be below 2**RES_W");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_GAP       = 3'd4
    } state_e;

    state_e              state_q;
    logic [CH_W-1:0]     ch_q;
    logic [CH_W-1:0]     ch_d;
    logic [31:0]         cnt_q;
    logic [TCNT_W-1:0]   tcnt_q;
    logic [RES_W-1:0]    wcnt_q;
    logic [N_CH-1:0]     trig_q;
    logic [N_CH-1:0]     valid_q;
    logic [N_CH-1:0]     to_q;
    logic [RES_W-1:0]    res_q [N_CH];
    logic [RES_W-1:0]    new_res;

    logic [N_CH-1:0]     echo_s1_q, echo_s2_q, echo_dly_q;
    logic [N_CH-1:0]     rise, fall;
    logic                rise_sel, fall_sel, tcnt_last, meas_done, to_done;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            echo_s1_q  <= '0;
            echo_s2_q  <= '0;
            echo_dly_q <= '0;
        end else begin
            echo_s1_q  <= echo;
            echo_s2_q  <= echo_s1_q;
            echo_dly_q <= echo_s2_q;
        end
    end

    assign rise     = echo_s2_q & ~echo_dly_q;
    assign fall     = ~echo_s2_q & echo_dly_q;
    assign rise_sel = rise[ch_q];
    assign fall_sel = fall[ch_q];

    // >= rather than ==: a rise on the last WAIT_RISE cycle carries tcnt past TO_LAST.
    assign tcnt_last = (tcnt_q >= TO_LAST);
    assign meas_done = (state_q == S_MEASURE) && fall_sel;
    assign to_done   = tcnt_last && (((state_q == S_WAIT_RISE) && !rise_sel) ||
                                     ((state_q == S_MEASURE) && !fall_sel));
    assign ch_d      = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            wcnt_q  <= '0;
            trig_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_TRIG;
                        cnt_q   <= '0;
                        trig_q  <= CH_ONE << ch_q;
                    end
                end
                S_TRIG: begin
                    if (cnt_q == TRIG_LAST) begin
                        trig_q  <= '0;
                        tcnt_q  <= '0;
                        state_q <= S_WAIT_RISE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_WAIT_RISE: begin
                    if (rise_sel) begin
                        state_q <= S_MEASURE;
                        wcnt_q  <= RES_W'(1);
                        tcnt_q  <= tcnt_q + TCNT_W'(1);
                    end else if (to_done) begin
                        state_q <= S_GAP;
                        cnt_q   <= '0;
                    end else begin
                        tcnt_q <= tcnt_q + TCNT_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (meas_done || to_done) begin
                        state_q <= S_GAP;
                        cnt_q   <= '0;
                    end else begin
                        tcnt_q <= tcnt_q + TCNT_W'(1);
                        if (wcnt_q != '1) begin
                            wcnt_q <= wcnt_q + RES_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        ch_q <= ch_d;
                        if (enable) begin
                            state_q <= S_TRIG;
                            cnt_q   <= '0;
                            trig_q  <= CH_ONE << ch_d;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    trig_q  <= '0;
                end
            endcase
        end
    end

`ifdef SONAR_ARRAY_FILTER_EN
    logic [N_CH-1:0]  first_q;
    logic [RES_W:0]   sum;

    assign sum     = {1'b0, res_q[ch_q]} + {1'b0, wcnt_q};
    assign new_res = first_q[ch_q] ? wcnt_q : sum[RES_W:1];

    // A channel restarts its average after reset or after any timeout.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            first_q <= '1;
        end else if (meas_done) begin
            first_q[ch_q] <= 1'b0;
        end else if (to_done) begin
            first_q[ch_q] <= 1'b1;
        end
    end
`else
    assign new_res = wcnt_q;
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            valid_q <= '0;
            to_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            valid_q <= '0;
            if (meas_done) begin
                res_q[ch_q]   <= new_res;
                to_q[ch_q]    <= 1'b0;
                valid_q[ch_q] <= 1'b1;
            end else if (to_done) begin
                res_q[ch_q]   <= '1;
                to_q[ch_q]    <= 1'b1;
                valid_q[ch_q] <= 1'b1;
            end
        end
    end

    always_comb begin
        result = '0;
        for (int i = 0; i < N_CH; i++) begin
            result[i*RES_W +: RES_W] = res_q[i];
        end
    end

    assign trig        = trig_q;
    assign valid       = valid_q;
    assign timeout     = to_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;
    assign dbg_ch_o    = 4'(ch_q);

endmodule

// File: tb/tb_sonar_array.sv
// Directed bench for sonar_array: table of per-channel echo responses plus hand sequences for enable drop and reset.
module tb_sonar_array;
    localparam int N_CH        = 2;
    localparam int TRIG_CYC    = 10;
    localparam int TIMEOUT_CYC = 1000;
    localparam int GAP_CYC     = 20;
    localparam int RES_W       = 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  enable;
    logic [N_CH-1:0]       echo;
    logic [N_CH-1:0]       trig;
    logic [N_CH*RES_W-1:0] result;
    logic [N_CH-1:0]       valid;
    logic [N_CH-1:0]       timeout;
    logic                  busy;
    logic [2:0]            dbg_state;
    logic [3:0]            dbg_ch;

    sonar_array #(
        .N_CH(N_CH), .TRIG_CYC(TRIG_CYC), .TIMEOUT_CYC(TIMEOUT_CYC),
        .GAP_CYC(GAP_CYC), .RES_W(RES_W)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable), .echo(echo),
        .trig(trig), .result(result), .valid(valid), .timeout(timeout),
        .busy(busy), .dbg_state_o(dbg_state), .dbg_ch_o(dbg_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        int          dly;
        int          wid;
        bit          stuck;
        logic [31:0] exp_res;
        bit          exp_to;
    } vec_t;

    localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

    vec_t        vecs [10];
    logic [31:0] exp_last [N_CH];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] slice(input int ch);
        return result[ch*RES_W +: RES_W];
    endfunction

    function automatic bit near(input logic [31:0] a, input logic [31:0] e);
        return (a == e) || (a == e + 32'd1) || (a + 32'd1 == e);
    endfunction

    function automatic logic [31:0] pick(input logic [31:0] raw, input logic [31:0] filt);
`ifdef SONAR_ARRAY_FILTER_EN
        return filt;
`else
        return raw;
`endif
    endfunction

    task automatic set_vec(input int i, input int ch, input int dly, input int wid, input bit stuck,
                           input logic [31:0] raw, input logic [31:0] filt, input bit to);
        vecs[i].ch      = ch;
        vecs[i].dly     = dly;
        vecs[i].wid     = wid;
        vecs[i].stuck   = stuck;
        vecs[i].exp_res = to ? ALL1 : pick(raw, filt);
        vecs[i].exp_to  = to;
    endtask

    // One channel slot: wait for its trigger, play the echo, then check the recorded result.
    task automatic run_meas(input int ch, input int dly, input int wid, input bit stuck,
                            input logic [31:0] exp_res, input bit exp_to, input int drop_at);
        int              t;
        int              cnt;
        int              lat;
        int              other;
        bit              seen;
        bit              oh_ok;
        logic [N_CH-1:0] oh;
        oh    = N_CH'(1) << ch;
        other = 1 - ch;
        if (stuck) echo[ch] = 1'b1;
        t = 0;
        while (!trig[ch] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("trig_start", trig[ch] == 1'b1, 64'(trig), 64'(oh));
        if (!trig[ch]) begin
            echo[ch] = 1'b0;
            return;
        end
        cnt   = 0;
        oh_ok = 1'b1;
        while (trig[ch] && cnt < 100) begin
            if (trig != oh) oh_ok = 1'b0;
            cnt++;
            @(negedge clk);
        end
        check("trig_width", cnt == TRIG_CYC, 64'(cnt), 64'(TRIG_CYC));
        check("trig_onehot", oh_ok, 64'(oh_ok), 64'd1);
        seen = 1'b0;
        lat  = 0;
        for (t = 0; t < 4000; t++) begin
            if (!stuck) echo[ch] = (t >= dly) && (t < dly + wid);
            if (t == drop_at) enable = 1'b0;
            if (seen) begin
                check("valid_pulse", valid == '0, 64'(valid), 64'd0);
                break;
            end
            if (valid != '0) begin
                seen = 1'b1;
                lat  = t;
                check("valid_onehot", valid == oh, 64'(valid), 64'(oh));
                if (exp_to) begin
                    check("result_to", slice(ch) == ALL1, 64'(slice(ch)), 64'(ALL1));
                    check("timeout_set", timeout[ch] == 1'b1, 64'(timeout), 64'(oh));
                    check("to_latency", lat == TIMEOUT_CYC, 64'(lat), 64'(TIMEOUT_CYC));
                end else begin
                    check("result", near(slice(ch), exp_res), 64'(slice(ch)), 64'(exp_res));
                    check("timeout_clr", timeout[ch] == 1'b0, 64'(timeout), 64'd0);
                end
                check("hold_other", near(slice(other), exp_last[other]),
                      64'(slice(other)), 64'(exp_last[other]));
                exp_last[ch] = exp_to ? ALL1 : exp_res;
            end
            @(negedge clk);
        end
        echo[ch] = 1'b0;
        if (!seen) check("valid_seen", 1'b0, 64'd0, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  t;
        bit  quiet;
        rst_n  = 1'b0;
        enable = 1'b0;
        echo   = '0;
        for (int i = 0; i < N_CH; i++) exp_last[i] = '0;

        set_vec(0, 0, 30,  200, 1'b0, 32'd200, 32'd200, 1'b0);
        set_vec(1, 1, 10,  300, 1'b0, 32'd300, 32'd300, 1'b0);
        set_vec(2, 0, 5,   100, 1'b0, 32'd100, 32'd150, 1'b0);
        set_vec(3, 1, 0,   0,   1'b0, 32'd0,   32'd0,   1'b1);
        set_vec(4, 0, 0,   0,   1'b1, 32'd0,   32'd0,   1'b1);
        set_vec(5, 1, 20,  50,  1'b0, 32'd50,  32'd50,  1'b0);
        set_vec(6, 0, 30,  2000, 1'b0, 32'd0,  32'd0,   1'b1);
        set_vec(7, 1, 0,   1,   1'b0, 32'd1,   32'd25,  1'b0);
        set_vec(8, 0, 10,  980, 1'b0, 32'd980, 32'd980, 1'b0);
        set_vec(9, 1, 3,   77,  1'b0, 32'd77,  32'd51,  1'b0);

        repeat (3) @(negedge clk);
        check("rst_trig",    trig == '0,    64'(trig),    64'd0);
        check("rst_result",  result == '0,  64'(result),  64'd0);
        check("rst_valid",   valid == '0,   64'(valid),   64'd0);
        check("rst_timeout", timeout == '0, 64'(timeout), 64'd0);
        check("rst_busy",    busy == 1'b0,  64'(busy),    64'd0);
        check("rst_ch",      dbg_ch == 4'd0, 64'(dbg_ch), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_enable", busy == 1'b0, 64'(busy), 64'd0);
        enable = 1'b1;
        @(negedge clk);
        check("trig_first", trig == 2'b01, 64'(trig), 64'd1);

        for (int i = 0; i < 10; i++) begin
            run_meas(vecs[i].ch, vecs[i].dly, vecs[i].wid, vecs[i].stuck,
                     vecs[i].exp_res, vecs[i].exp_to, -1);
        end

        // enable falls mid-MEASURE on ch0: result still lands, scan parks in IDLE on ch1
        run_meas(0, 10, 100, 1'b0, pick(32'd100, 32'd540), 1'b0, 60);
        t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("stop_idle",  busy == 1'b0,      64'(busy),      64'd0);
        check("stop_state", dbg_state == 3'd0, 64'(dbg_state), 64'd0);
        check("stop_ch",    dbg_ch == 4'd1,    64'(dbg_ch),    64'd1);
        quiet = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (trig != '0) quiet = 1'b0;
        end
        check("no_trig_disabled", quiet, 64'(quiet), 64'd1);
        enable = 1'b1;
        @(negedge clk);
        check("restart_ch1", trig == 2'b10, 64'(trig), 64'd2);

        // asynchronous reset in the middle of the ch1 trigger pulse
        repeat (3) @(negedge clk);
        check("trig_before_rst", trig == 2'b10, 64'(trig), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_trig",    trig == '0,    64'(trig),    64'd0);
        check("arst_result",  result == '0,  64'(result),  64'd0);
        check("arst_valid",   valid == '0,   64'(valid),   64'd0);
        check("arst_timeout", timeout == '0, 64'(timeout), 64'd0);
        check("arst_busy",    busy == 1'b0,  64'(busy),    64'd0);
        check("arst_ch",      dbg_ch == 4'd0, 64'(dbg_ch), 64'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_idle", (trig == '0) && !busy, 64'({busy, trig}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
